timer_share_arbiter: RTL and testbench

//  Shares the single user-project countdown timer among NREQ on-chip requesters.

---
 rtl/timer_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 50 +++++
 rtl/timer_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_timer_share_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// Shared types and limits for the timer-sharing arbiter.
//   arb_state_e : arbiter FSM states, 2-bit encoding
//   NREQ_MAX    : largest supported number of requesters
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i         : request vector
//   last_i        : index of the previously served requester
//   grant_valid_o : at least one request present
//   grant_idx_o   : first requester at or after (last_i+1) mod NREQ, with wrap
// The request vector is rotated so that position 0 is (last_i+1), the lowest
// set bit is found, and the offset is added back modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            grant_valid_o,
  output logic [IW-1:0]   grant_idx_o
);

  logic [IW-1:0]   start_idx;
  logic [NREQ-1:0] req_rot;
  int              pick;
  int              sum;

  // Start scanning just past the last owner, wrapping at NREQ (which need
  // not be a power of two).
  assign start_idx = (int'(last_i) >= NREQ - 1) ? '0 : last_i + IW'(1);

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rot[i] = req_i[IW'((int'(start_idx) + i) % NREQ)];
    end
  end

  always_comb begin
    pick = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick = i;
      end
    end
    sum = int'(start_idx) + pick;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    grant_valid_o = |req_rot;
    grant_idx_o   = IW'(sum);
  end

endmodule

// File: rtl/timer_share_arbiter.sv
// Shares one countdown timer among NREQ requesters.
// A requester is chosen round-robin, its delay is loaded into the timer, the
// timer runs and the owner is told when it expires (or it may cancel).
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   req_i / req_val_i  : level requests and flattened per-requester delays
//   cancel_i           : owner abort of its running delay
//   ack_o / done_o     : one-cycle accept / expiry pulses to the owner
//   busy_o, owner_o    : timer ownership status, current/last owner index
//   tmr_load_o/val_o   : load strobe and value to the timer
//   tmr_en_o           : timer count enable
//   tmr_expired_i      : timer expiry pulse, only honoured while running
// Every output comes straight from a flop: the registered values are the
// outputs that belong to the state being entered.
module timer_share_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*W-1:0]       req_val_i,
  input  logic [NREQ-1:0]         cancel_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    tmr_load_o,
  output logic [W-1:0]            tmr_val_o,
  output logic                    tmr_en_o,
  input  logic                    tmr_expired_i
);

  localparam int IW = $clog2(NREQ);

  generate
    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("timer_share_arbiter: NREQ out of range");
    end
  endgenerate

  // Unpack the flattened delay bus.
  logic [W-1:0] req_val_arr [NREQ];
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_val_arr[gi] = req_val_i[gi*W +: W];
    end
  endgenerate

  arb_state_e      state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [W-1:0]    val_reg, val_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            busy_reg, busy_next;
  logic            load_reg, load_next;
  logic [W-1:0]    tval_reg, tval_next;
  logic            en_reg, en_next;

  logic            grant_valid;
  logic [IW-1:0]   grant_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i         (req_i),
    .last_i        (last_reg),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      val_reg   <= '0;
      last_reg  <= IW'(NREQ - 1);  // requester 0 wins the first scan
      ack_reg   <= '0;
      done_reg  <= '0;
      busy_reg  <= 1'b0;
      load_reg  <= 1'b0;
      tval_reg  <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      val_reg   <= val_next;
      last_reg  <= last_next;
      ack_reg   <= ack_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      load_reg  <= load_next;
      tval_reg  <= tval_next;
      en_reg    <= en_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    val_next   = val_reg;
    last_next  = last_reg;
    ack_next   = '0;
    done_next  = '0;
    load_next  = 1'b0;
    tval_next  = '0;
    en_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next           = grant_idx;
          val_next             = req_val_arr[grant_idx];
          ack_next[grant_idx]  = 1'b1;
          load_next            = 1'b1;
          tval_next            = req_val_arr[grant_idx];
          state_next           = LOAD;
        end
      end
      LOAD: begin
        // A zero delay skips the timer entirely and completes at once.
        if (val_reg == '0) begin
          done_next[owner_reg] = 1'b1;
          state_next           = DONE;
        end else begin
          en_next    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Expiry takes precedence over a simultaneous owner cancel.
        if (tmr_expired_i) begin
          done_next[owner_reg] = 1'b1;
          state_next           = DONE;
        end else if (cancel_i[owner_reg]) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end else begin
          en_next = 1'b1;
        end
      end
      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign ack_o      = ack_reg;
  assign done_o     = done_reg;
  assign busy_o     = busy_reg;
  assign owner_o    = owner_reg;
  assign tmr_load_o = load_reg;
  assign tmr_val_o  = tval_reg;
  assign tmr_en_o   = en_reg;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench for timer_share_arbiter: the stimulus side predicts each
// grant from the round-robin rule and queues the expected ack/done events; a
// monitor pops and compares whenever the DUT pulses ack_o or done_o.
module tb_timer_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IW   = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_val;
  logic [NREQ-1:0]     cancel;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     done;
  logic                busy;
  logic [IW-1:0]       owner;
  logic                tmr_load;
  logic [W-1:0]        tmr_val;
  logic                tmr_en;
  logic                tmr_expired;

  always #5 clk = ~clk;

  timer_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .req_i         (req),
    .req_val_i     (req_val),
    .cancel_i      (cancel),
    .ack_o         (ack),
    .done_o        (done),
    .busy_o        (busy),
    .owner_o       (owner),
    .tmr_load_o    (tmr_load),
    .tmr_val_o     (tmr_val),
    .tmr_en_o      (tmr_en),
    .tmr_expired_i (tmr_expired)
  );

  typedef struct {
    bit is_done;
    int idx;
    int val;
  } exp_t;

  exp_t            exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [NREQ-1:0] mask;
  logic [W-1:0]    vals [NREQ];
  int              last_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference rule: first requesting index after the last owner, with wrap.
  function automatic int pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_req();
    req = mask;
    for (int k = 0; k < NREQ; k++) req_val[k*W +: W] = vals[k];
  endtask

  // Monitor: compare every ack/done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("en_implies_busy", 64'(tmr_en & ~busy), 64'(0));
      if (ack != 0 || done != 0) begin
        check("ack_done_excl", 64'((ack != 0) && (done != 0)), 64'(0));
        check("ack_onehot", 64'($countones(ack) <= 1), 64'(1));
        check("done_onehot", 64'($countones(done) <= 1), 64'(1));
      end
      if (ack != 0) begin
        if (exp_q.size() == 0) check("unexpected_ack", 64'(ack), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("ack_vec", 64'(ack), e.is_done ? 64'(0) : (64'(1) << e.idx));
          check("ack_load", 64'(tmr_load), 64'(1));
          check("ack_val", 64'(tmr_val), 64'(e.val));
        end
      end
      if (done != 0) begin
        if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("done_vec", 64'(done), e.is_done ? (64'(1) << e.idx) : 64'(0));
          check("done_en_low", 64'(tmr_en), 64'(0));
        end
      end
    end
  end

  function automatic logic [NREQ-1:0] noise(input int w);
    logic [NREQ-1:0] n;
    n = NREQ'($urandom);
    n[w] = 1'b0;
    return n;
  endfunction

  // One grant-to-completion transaction. Called at a negedge with DUT idle.
  // act: 0 = expire, 1 = owner cancel, 2 = expire+cancel together, -1 = random.
  task automatic run_round(input int act_sel);
    int w, v, act, wait_n, bound;
    w = pick(mask, last_m);
    if (w < 0) return;
    v = int'(vals[w]);
    act = (act_sel >= 0) ? act_sel : int'($urandom_range(0, 2));
    exp_q.push_back('{is_done: 1'b0, idx: w, val: v});
    if (v == 0 || act != 1) exp_q.push_back('{is_done: 1'b1, idx: w, val: 0});
    last_m = w;
    drive_req();
    @(negedge clk);
    check("ack_latency", 64'(ack), 64'(1) << w);
    check("owner", 64'(owner), 64'(w));
    mask[w] = 1'b0;
    drive_req();
    if (v != 0) begin
      @(negedge clk);
      check("en_after_load", 64'(tmr_en), 64'(1));
      wait_n = (act == 0) ? v - 1 : int'($urandom_range(0, v - 1));
      for (int i = 0; i < wait_n; i++) begin
        cancel = noise(w);
        @(negedge clk);
        check("en_running", 64'(tmr_en), 64'(1));
      end
      tmr_expired = (act != 1);
      cancel = noise(w);
      if (act != 0) cancel[w] = 1'b1;
      @(negedge clk);
      tmr_expired = 1'b0;
      cancel = '0;
      if (act == 1) begin
        check("cancel_busy", 64'(busy), 64'(0));
        check("cancel_en", 64'(tmr_en), 64'(0));
      end else begin
        check("expire_done", 64'(done), 64'(1) << w);
      end
    end else begin
      @(negedge clk);
      check("zero_done", 64'(done), 64'(1) << w);
      check("zero_en", 64'(tmr_en), 64'(0));
    end
    bound = 0;
    while (busy && bound < 8) begin
      @(negedge clk);
      bound++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
    $display("round: owner=%0d val=%0d act=%0d", w, v, act);
  endtask

  task automatic idle_window();
    logic [NREQ-1:0] nb;
    if (mask == 0 && $urandom_range(0, 1) == 1) begin
      req = '0;
      tmr_expired = 1'b1;
      @(negedge clk);
      tmr_expired = 1'b0;
      @(negedge clk);
      check("idle_expire_ignored", 64'(busy), 64'(0));
    end
    nb = NREQ'($urandom) & ~mask;
    if (mask == 0 && nb == 0) nb[$urandom_range(0, NREQ - 1)] = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (nb[k]) vals[k] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 6));
    end
    mask = mask | nb;
    drive_req();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_val = '0;
    cancel = '0;
    tmr_expired = 1'b0;
    mask = '0;
    last_m = NREQ - 1;
    for (int k = 0; k < NREQ; k++) vals[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_load", 64'(tmr_load), 64'(0));
    check("rst_val", 64'(tmr_val), 64'(0));
    check("rst_en", 64'(tmr_en), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single requester, delay 5, normal expiry.
    mask = 4'b0001; vals[0] = 16'd5; run_round(0);
    // Zero delay from requester 2.
    mask = 4'b0100; vals[2] = 16'd0; run_round(-1);
    // Requester 1 cancels its running delay.
    mask = 4'b0010; vals[1] = 16'd6; run_round(1);
    // Expire and cancel together.
    mask = 4'b1000; vals[3] = 16'd4; run_round(2);
    // All four held: order 0,1,2,3 then 0 again after re-raise.
    mask = 4'b1111;
    for (int k = 0; k < NREQ; k++) vals[k] = W'(k + 2);
    for (int r = 0; r < NREQ; r++) run_round(0);
    mask = 4'b1111; run_round(0);
    mask = '0;

    for (int r = 0; r < 150; r++) begin
      idle_window();
      run_round(-1);
    end

    // Reset in the middle of a run.
    mask = 4'b0100; vals[2] = 16'd50;
    exp_q.push_back('{is_done: 1'b0, idx: pick(mask, last_m), val: 50});
    drive_req();
    @(negedge clk);
    mask = '0; drive_req();
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_en", 64'(tmr_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_en", 64'(tmr_en), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_owner", 64'(owner), 64'(0));
    check("arst_ack_done", 64'({ack, done}), 64'(0));
    exp_q.delete();
    last_m = NREQ - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mask = 4'b1001; vals[0] = 16'd3; vals[3] = 16'd2;
    run_round(0);
    run_round(0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
